arbiter_puf_driver: RTL and testbench

- Drives the challenge side of an arbiter PUF and collects the arbiter's response bit.
- The arbiter itself is the existing one-bit capture flip-flop. This block generates the stimulus it races against, fires the launch edge, waits for the race to resolve, and then samples the flip-flop's Q.
- A host seeds a challenge and receives a RESP_BITS-wide response word over a valid/ready handshake.

---
 rtl/puf_defs.sv | 25 ++
 rtl/puf_lfsr.sv | 36 +++
 rtl/arbiter_puf_driver.sv | 117 +++++++++++
 tb/tb_arbiter_puf_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_defs.sv
// Shared definitions for the arbiter PUF driver.
// State encodings, default LFSR taps and per-bit cycle cost.
package puf_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LAUNCH,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [63:0] DEF_LFSR_TAPS = 64'hD800_0000_0000_0000;

  localparam int DEF_SETTLE  = 4;
  localparam int DEF_CAPTURE = 4;

  function automatic int bit_cost(input int settle, input int capture);
    return settle + capture + 2;
  endfunction

  localparam int BIT_CYCLES = bit_cost(DEF_SETTLE, DEF_CAPTURE);

endpackage

// File: rtl/puf_lfsr.sv
// Fibonacci LFSR that holds the challenge applied to the PUF.
// An all-zero seed is replaced by 1 so the register never locks up.
module puf_lfsr
  import puf_defs::*;
#(
  parameter int                CHAL_W    = 64,
  parameter logic [CHAL_W-1:0] LFSR_TAPS = CHAL_W'(DEF_LFSR_TAPS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [CHAL_W-1:0] seed_i,
  input  logic              step_i,
  output logic [CHAL_W-1:0] state_o
);

  logic [CHAL_W-1:0] lfsr_q;
  logic [CHAL_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? CHAL_W'(1) : seed_i;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[CHAL_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= '0;
    else       lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/arbiter_puf_driver.sv
// Arbiter PUF driver: settles a challenge, fires the race, samples
// the arbiter and shifts RESP_BITS results into a response word.
module arbiter_puf_driver
  import puf_defs::*;
#(
  parameter int                CHAL_W         = 64,
  parameter int                RESP_BITS      = 8,
  parameter int                SETTLE_CYCLES  = DEF_SETTLE,
  parameter int                CAPTURE_CYCLES = DEF_CAPTURE,
  parameter logic [CHAL_W-1:0] LFSR_TAPS      = CHAL_W'(DEF_LFSR_TAPS)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [CHAL_W-1:0]    Seed,
  output logic                 Busy,
  output logic [CHAL_W-1:0]    Challenge,
  output logic                 Launch,
  input  logic                 Arb_q,
  output logic [RESP_BITS-1:0] Response,
  output logic                 Resp_valid,
  input  logic                 Resp_ready
);

  localparam int CYC_MAX = (SETTLE_CYCLES > CAPTURE_CYCLES) ?
                           SETTLE_CYCLES : CAPTURE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int BIT_W   = $clog2(RESP_BITS + 1);

  state_e               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic                 lfsr_load;
  logic                 lfsr_step;

  puf_lfsr #(
    .CHAL_W    (CHAL_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .load_i  (lfsr_load),
    .seed_i  (Seed),
    .step_i  (lfsr_step),
    .state_o (Challenge)
  );

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    resp_d    = resp_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          lfsr_load = 1'b1;
          resp_d    = '0;
          bit_d     = '0;
          cyc_d     = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ST_LAUNCH;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cyc_q == CYC_W'(CAPTURE_CYCLES - 1)) begin
          cyc_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_SAMPLE: begin
        // first evaluation ends up in the MSB
        resp_d    = {resp_q[RESP_BITS-2:0], Arb_q};
        lfsr_step = 1'b1;
        bit_d     = bit_q + BIT_W'(1);
        state_d   = (bit_q == BIT_W'(RESP_BITS - 1)) ?
                    ST_DONE : ST_SETUP;
      end
      ST_DONE: begin
        if (Resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      resp_q  <= resp_d;
    end
  end

  assign Busy       = (state_q != ST_IDLE);
  assign Launch     = (state_q == ST_LAUNCH);
  assign Resp_valid = (state_q == ST_DONE);
  assign Response   = resp_q;

endmodule

// File: tb/tb_arbiter_puf_driver.sv
// Self-checking bench for arbiter_puf_driver.
// Table-driven jobs plus hand-written handshake and reset sequences.
module tb_arbiter_puf_driver;
  import puf_defs::*;

  localparam int CW  = 64;
  localparam int RB  = 8;
  localparam int LAT = RB * BIT_CYCLES;

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic [CW-1:0] Seed;
  logic          Busy;
  logic [CW-1:0] Challenge;
  logic          Launch;
  logic          Arb_q;
  logic [RB-1:0] Response;
  logic          Resp_valid;
  logic          Resp_ready;

  arbiter_puf_driver dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Seed       (Seed),
    .Busy       (Busy),
    .Challenge  (Challenge),
    .Launch     (Launch),
    .Arb_q      (Arb_q),
    .Response   (Response),
    .Resp_valid (Resp_valid),
    .Resp_ready (Resp_ready)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [CW-1:0] seed;
    logic [RB-1:0] pat;
    logic [CW-1:0] chal2;
  } vec_t;

  vec_t          tbl[4];
  logic [RB-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] lfsr_next(input logic [CW-1:0] s);
    return {s[CW-2:0], ^(s & DEF_LFSR_TAPS)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Arb_q follows pat MSB-first, switched right after each launch
  task automatic run_job(input logic [CW-1:0] seed,
                         input logic [RB-1:0] pat,
                         input logic [CW-1:0] chal2,
                         input bit hold);
    int            n;
    int            k;
    int            last;
    bit            prev_l;
    bit            done;
    logic [CW-1:0] ec;
    logic [RB-1:0] er;
    ec    = (seed == '0) ? 64'h1 : seed;
    Seed  = seed;
    Start = 1'b1;
    Arb_q = ~pat[RB-1];
    exp_q.push_back(pat);
    tick();
    if (!hold) Start = 1'b0;
    n = 0; k = 0; last = 0; prev_l = 1'b0; done = 1'b0;
    while (n <= LAT + 20 && !done) begin
      if (Launch) begin
        chk("launch_width", 64'(prev_l), 64'd0);
        if (k == 0) begin
          chk("first_launch_at", 64'(n), 64'(DEF_SETTLE));
          chk("resp_cleared", 64'(Response), 64'd0);
        end else begin
          chk("launch_gap", 64'(n - last), 64'(BIT_CYCLES));
        end
        chk("chal_at_launch", Challenge, ec);
        if (k == 1) chk("second_chal", Challenge, chal2);
        if (k < RB) Arb_q = pat[RB-1-k];
        ec   = lfsr_next(ec);
        last = n;
        k++;
      end
      prev_l = Launch;
      if (Resp_valid) begin
        done = 1'b1;
        chk("latency", 64'(n), 64'(LAT));
        chk("launch_count", 64'(k), 64'(RB));
        chk("final_chal", Challenge, ec);
        chk("busy_done", 64'(Busy), 64'd1);
        if (exp_q.size() > 0) begin
          er = exp_q.pop_front();
          chk("response", 64'(Response), 64'(er));
        end else begin
          chk("scoreboard_underflow", 64'(exp_q.size()), 64'd1);
        end
      end else begin
        tick();
        n++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout got no Resp_valid want %0d cycles", LAT);
    end
  endtask

  task automatic ack();
    Resp_ready = 1'b1;
    tick();
    Resp_ready = 1'b0;
    chk("valid_drop", 64'(Resp_valid), 64'd0);
    chk("idle_after_ack", 64'(Busy), 64'd0);
  endtask

  initial begin
    bit stable;
    int nl;
    tbl[0] = '{64'h1, 8'hFF, 64'h2};
    tbl[1] = '{64'h0, 8'h00, 64'h2};
    tbl[2] = '{64'h8000_0000_0000_0000, 8'hB2, 64'h1};
    tbl[3] = '{64'hDEAD_BEEF_0123_4567, 8'h5A, 64'hBD5B_7DDE_0246_8ACE};

    Reset = 1'b1; Start = 1'b0; Seed = '0;
    Arb_q = 1'b0; Resp_ready = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_launch", 64'(Launch), 64'd0);
    chk("rst_chal", Challenge, 64'd0);
    chk("rst_resp", 64'(Response), 64'd0);
    chk("rst_valid", 64'(Resp_valid), 64'd0);
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_job(tbl[i].seed, tbl[i].pat, tbl[i].chal2, 1'b0);
      if (i == 2) begin
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
          tick();
          if (!(Resp_valid && Response == 8'hB2)) stable = 1'b0;
        end
        chk("hold_stable", 64'(stable), 64'd1);
        Resp_ready = 1'b1;
        Start = 1'b1;
        tick();
        Resp_ready = 1'b0;
        Start = 1'b0;
        chk("ack_start_valid", 64'(Resp_valid), 64'd0);
        chk("ack_start_idle", 64'(Busy), 64'd0);
        tick();
        chk("no_new_job", 64'(Busy), 64'd0);
        chk("resp_kept", 64'(Response), 64'hB2);
      end else begin
        ack();
      end
      tick();
    end

    Seed = 64'h1; Start = 1'b1; Arb_q = 1'b1;
    exp_q.push_back(8'hFF);
    tick();
    Start = 1'b0;
    nl = 0;
    for (int c = 0; c < LAT && nl < 3; c++) begin
      if (Launch) nl++;
      if (nl < 3) tick();
    end
    chk("third_launch_seen", 64'(nl), 64'd3);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_q.delete();
    chk("midrst_busy", 64'(Busy), 64'd0);
    chk("midrst_launch", 64'(Launch), 64'd0);
    chk("midrst_chal", Challenge, 64'd0);
    chk("midrst_resp", 64'(Response), 64'd0);
    tick();
    run_job(64'h1, 8'hFF, 64'h2, 1'b0);
    ack();
    tick();

    run_job(64'h1, 8'h3C, 64'h2, 1'b1);
    Resp_ready = 1'b1;
    tick();
    Resp_ready = 1'b0;
    chk("held_start_idle", 64'(Busy), 64'd0);
    chk("held_start_valid", 64'(Resp_valid), 64'd0);
    tick();
    chk("held_start_next_job", 64'(Busy), 64'd1);
    Start = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
